// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// ----------------
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// flags, overflow/underflow error pulses and an optional first-word-fall-through
// read mode.
//
// Parameters:
//   DATA_WIDTH - width of din/dout
//   ADDR_WIDTH - pointer width, the FIFO holds DEPTH = 2**ADDR_WIDTH entries
//   ALF_VALUE  - alf is high while count >= ALF_VALUE (1..DEPTH)
//   ALE_VALUE  - ale is high while count <= ALE_VALUE (0..DEPTH-1)
//   FWFT       - 0: dout loaded one cycle after a read, 1: dout shows the head entry
//
// Ports:
//   clk       - clock, everything happens on the rising edge
//   reset     - synchronous active-high reset
//   din       - write data
//   write     - write request
//   read      - read request
//   dout      - read data
//   empty     - count == 0
//   full      - count == DEPTH
//   ale       - almost empty
//   alf       - almost full
//   count     - current occupancy, 0..DEPTH
//   overflow  - one-cycle pulse after a rejected write
//   underflow - one-cycle pulse after a rejected read
module sync_fifo_param #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int ALF_VALUE  = 14,
   parameter int ALE_VALUE  = 2,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  write,
   input  logic                  read,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  empty,
   output logic                  full,
   output logic                  ale,
   output logic                  alf,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [ADDR_WIDTH:0]   DEPTH_CNT  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   ALF_THRESH = (ADDR_WIDTH+1)'(ALF_VALUE);
   localparam logic [ADDR_WIDTH:0]   ALE_THRESH = (ADDR_WIDTH+1)'(ALE_VALUE);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

   // Thresholds outside the legal range would make alf/ale meaningless,
   // so refuse to elaborate rather than build a silently broken FIFO.
   if (ALF_VALUE > DEPTH || ALF_VALUE < 1 || ALE_VALUE >= DEPTH || ALE_VALUE < 0) begin : g_bad_params
      $fatal(1, "sync_fifo_param: ALF_VALUE must be 1..DEPTH and ALE_VALUE 0..DEPTH-1");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] wr_ptr_next;
   logic [ADDR_WIDTH-1:0] rd_ptr_next;
   logic [ADDR_WIDTH:0]   count_next;
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] head_data;

   // Accept logic and next-state bookkeeping. A write into a full FIFO is
   // still taken when a read frees a slot on the same edge; a read of an
   // empty FIFO is always refused, even if a write arrives alongside it.
   // head_data is the entry that will sit at the head after this edge,
   // bypassing the memory when that entry is the one being written now.
   always_comb begin
      rd_en       = read & ~empty;
      wr_en       = write & (~full | rd_en);
      wr_ptr_next = wr_ptr;
      rd_ptr_next = rd_ptr;
      count_next  = count;
      if (wr_en) begin
         wr_ptr_next = wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
         rd_ptr_next = rd_ptr + PTR_ONE;
      end
      case ({wr_en, rd_en})
         2'b10:   count_next = count + CNT_ONE;
         2'b01:   count_next = count - CNT_ONE;
         default: count_next = count;
      endcase
      if (wr_en && (rd_ptr_next == wr_ptr)) begin
         head_data = din;
      end else begin
         head_data = mem[rd_ptr_next];
      end
   end

   // Storage array. It is deliberately not cleared on reset; the pointers
   // and count going back to zero are enough to discard its contents.
   // A write presented together with reset must not land in memory.
   always_ff @(posedge clk) begin
      if (!reset && wr_en) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer, occupancy and status registers. The flags are derived from
   // count_next so they move on the same edge as count instead of a cycle
   // later. Error pulses last one cycle because they are recomputed on
   // every edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         empty     <= 1'b1;
         full      <= 1'b0;
         ale       <= 1'b1;
         alf       <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_next;
         rd_ptr    <= rd_ptr_next;
         count     <= count_next;
         empty     <= (count_next == '0);
         full      <= (count_next == DEPTH_CNT);
         ale       <= (count_next <= ALE_THRESH);
         alf       <= (count_next >= ALF_THRESH);
         overflow  <= write & ~wr_en;
         underflow <= read & ~rd_en;
      end
   end

   // Read data register. In standard mode it captures the popped entry, so
   // data follows the read by one cycle. In FWFT mode it always tracks the
   // next head entry, so a word written into an empty FIFO is visible one
   // cycle later without a read. Both modes hold the last word once the
   // FIFO runs empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         dout <= '0;
      end else if (FWFT != 0) begin
         if (count_next != '0) begin
            dout <= head_data;
         end
      end else begin
         if (rd_en) begin
            dout <= mem[rd_ptr];
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param
// -------------------
// Directed self-checking bench for sync_fifo_param. Two instances share the
// same stimulus: one in standard read mode and one in first-word-fall-through
// mode, both with default sizes (16 entries, alf at 14, ale at 2).
module tb_sync_fifo_param;

   logic       clk;
   logic       reset;
   logic [7:0] din;
   logic       write;
   logic       read;

   logic [7:0] dout;
   logic       empty;
   logic       full;
   logic       ale;
   logic       alf;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   logic [7:0] f_dout;
   logic       f_empty;
   logic       f_full;
   logic       f_ale;
   logic       f_alf;
   logic [4:0] f_count;
   logic       f_overflow;
   logic       f_underflow;

   int errors = 0;
   int checks = 0;

   logic [7:0] model_q [$];
   logic [7:0] exp_data;

   sync_fifo_param #(.FWFT(0)) dut (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .write     (write),
      .read      (read),
      .dout      (dout),
      .empty     (empty),
      .full      (full),
      .ale       (ale),
      .alf       (alf),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   sync_fifo_param #(.FWFT(1)) dut_fwft (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .write     (write),
      .read      (read),
      .dout      (f_dout),
      .empty     (f_empty),
      .full      (f_full),
      .ale       (f_ale),
      .alf       (f_alf),
      .count     (f_count),
      .overflow  (f_overflow),
      .underflow (f_underflow)
   );

   // Free-running 10 time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs, clock them in and settle just after the edge
   // so outputs can be sampled away from the active edge.
   task automatic applyStimulus(input logic rst, input logic w, input logic r, input logic [7:0] d);
      reset = rst;
      write = w;
      read  = r;
      din   = d;
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its expectation and count the result.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Directed sequence: reset, fill, drain, simultaneous access, wrap-around,
   // fall-through read and reset in the middle of traffic.
   initial begin
      reset = 1'b1;
      write = 1'b0;
      read  = 1'b0;
      din   = 8'h00;

      $display("[TB] reset");
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_ale", 32'(ale), 32'd1);
      checkOutput("rst_alf", 32'(alf), 32'd0);
      checkOutput("rst_dout", 32'(dout), 32'd0);
      checkOutput("rst_overflow", 32'(overflow), 32'd0);
      checkOutput("rst_underflow", 32'(underflow), 32'd0);
      checkOutput("rst_fwft_dout", 32'(f_dout), 32'd0);

      $display("[TB] fill");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 8'(i));
         checkOutput("fill_count", 32'(count), 32'(i + 1));
         checkOutput("fill_full", 32'(full), (i == 15) ? 32'd1 : 32'd0);
         checkOutput("fill_alf", 32'(alf), (i >= 13) ? 32'd1 : 32'd0);
         checkOutput("fill_ale", 32'(ale), (i <= 1) ? 32'd1 : 32'd0);
         checkOutput("fill_empty", 32'(empty), 32'd0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h10);
      checkOutput("ovf_pulse", 32'(overflow), 32'd1);
      checkOutput("ovf_count", 32'(count), 32'd16);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("ovf_clear", 32'(overflow), 32'd0);
      checkOutput("ovf_count_hold", 32'(count), 32'd16);

      $display("[TB] drain");
      for (int i = 0; i < 16; i++) begin
         checkOutput("drain_fwft_head", 32'(f_dout), 32'(i));
         applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
         checkOutput("drain_dout", 32'(dout), 32'(i));
         checkOutput("drain_count", 32'(count), 32'(15 - i));
         checkOutput("drain_empty", 32'(empty), (i == 15) ? 32'd1 : 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("udf_pulse", 32'(underflow), 32'd1);
      checkOutput("udf_dout_hold", 32'(dout), 32'h0F);
      checkOutput("udf_count", 32'(count), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("udf_clear", 32'(underflow), 32'd0);
      checkOutput("udf_dout_hold2", 32'(dout), 32'h0F);
      checkOutput("udf_fwft_hold", 32'(f_dout), 32'h0F);

      $display("[TB] simultaneous read/write when full");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 8'(i));
      end
      checkOutput("rw_full_pre", 32'(full), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b1, 8'hAA);
      checkOutput("rw_full_count", 32'(count), 32'd16);
      checkOutput("rw_full_ovf", 32'(overflow), 32'd0);
      checkOutput("rw_full_dout", 32'(dout), 32'h00);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
         checkOutput("rw_full_drain", 32'(dout), (i < 15) ? 32'(i + 1) : 32'hAA);
      end
      checkOutput("rw_full_empty", 32'(empty), 32'd1);

      $display("[TB] simultaneous read/write when empty");
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h33);
      checkOutput("rw_empty_count", 32'(count), 32'd1);
      checkOutput("rw_empty_udf", 32'(underflow), 32'd1);
      checkOutput("rw_empty_empty", 32'(empty), 32'd0);
      checkOutput("rw_empty_dout", 32'(dout), 32'hAA);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("rw_empty_udf_clear", 32'(underflow), 32'd0);

      $display("[TB] wrap-around");
      model_q.push_back(8'h33);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
         model_q.push_back(8'(8'h60 + i));
      end
      checkOutput("wrap_prefill", 32'(count), 32'd5);
      for (int k = 0; k < 40; k++) begin
         logic w;
         logic r;
         w = (k % 8) != 4;
         r = (k % 8) != 0;
         applyStimulus(1'b0, w, r, 8'(8'h80 + k));
         if (r) begin
            exp_data = model_q.pop_front();
            checkOutput("wrap_dout", 32'(dout), 32'(exp_data));
         end
         if (w) begin
            model_q.push_back(8'(8'h80 + k));
         end
         checkOutput("wrap_count", 32'(count), 32'(model_q.size()));
      end
      while (model_q.size() > 0) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
         exp_data = model_q.pop_front();
         checkOutput("wrap_tail", 32'(dout), 32'(exp_data));
      end
      checkOutput("wrap_empty", 32'(empty), 32'd1);

      $display("[TB] first-word-fall-through");
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("fwft_rst_empty", 32'(f_empty), 32'd1);
      checkOutput("fwft_rst_dout", 32'(f_dout), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h5C);
      checkOutput("fwft_dout", 32'(f_dout), 32'h5C);
      checkOutput("fwft_empty", 32'(f_empty), 32'd0);
      checkOutput("std_dout_no_read", 32'(dout), 32'h00);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("fwft_pop_empty", 32'(f_empty), 32'd1);
      checkOutput("fwft_pop_hold", 32'(f_dout), 32'h5C);
      checkOutput("std_dout_read", 32'(dout), 32'h5C);

      $display("[TB] reset mid-operation");
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
      end
      checkOutput("mid_pre_count", 32'(count), 32'd9);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF);
      checkOutput("mid_count", 32'(count), 32'd0);
      checkOutput("mid_empty", 32'(empty), 32'd1);
      checkOutput("mid_ale", 32'(ale), 32'd1);
      checkOutput("mid_alf", 32'(alf), 32'd0);
      checkOutput("mid_full", 32'(full), 32'd0);
      checkOutput("mid_dout", 32'(dout), 32'd0);
      checkOutput("mid_overflow", 32'(overflow), 32'd0);
      checkOutput("mid_underflow", 32'(underflow), 32'd0);
      checkOutput("mid_fwft_dout", 32'(f_dout), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("mid_after_count", 32'(count), 32'd0);
      checkOutput("mid_after_udf", 32'(underflow), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
